// File: rtl/ctx_pkg.sv
// Shared state encoding and register-range constants for the context save/restore engine.
// Honours CTX_SKIP_ZERO_EN: when defined, register 0 is excluded from save and restore.
package ctx_pkg;

  typedef enum logic [2:0] {
    CTX_IDLE    = 3'd0,
    CTX_SAVE    = 3'd1,
    CTX_REST_RD = 3'd2,
    CTX_REST_WR = 3'd3,
    CTX_DONE    = 3'd4
  } ctx_state_t;

  localparam int         CTX_NREGS    = 32;
  localparam logic [4:0] CTX_LAST_IDX = 5'(CTX_NREGS - 1);

`ifdef CTX_SKIP_ZERO_EN
  localparam logic [4:0] CTX_FIRST_IDX = 5'd1;
`else
  localparam logic [4:0] CTX_FIRST_IDX = 5'd0;
`endif

endpackage

// File: rtl/ctx_switch_unit_if.sv
// Control, register-file and data-memory signals of the context save/restore engine.
// The engine takes the slave side; control logic, register file and memory sit on master.
interface ctx_switch_unit_if;
  logic        save_req;
  logic        restore_req;
  logic [31:0] base_addr;
  logic        busy;
  logic        done;
  logic [4:0]  reg_addr;
  logic        reg_bank;
  logic [31:0] reg_rdata;
  logic [31:0] reg_wdata;
  logic        reg_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  save_req, restore_req, base_addr, reg_rdata, mem_rdata, mem_ready,
    output busy, done, reg_addr, reg_bank, reg_wdata, reg_write,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output save_req, restore_req, base_addr, reg_rdata, mem_rdata, mem_ready,
    input  busy, done, reg_addr, reg_bank, reg_wdata, reg_write,
           mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/ctx_switch_unit.sv
// Saves the program register bank to consecutive memory words and restores it back.
// Build option CTX_SKIP_ZERO_EN (see ctx_pkg) starts both transfers at register 1.
module ctx_switch_unit
  import ctx_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  ctx_switch_unit_if.slave  bus
);

  ctx_state_t  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] base_q, base_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    data_d  = data_q;
    unique case (state_q)
      CTX_IDLE: begin
        // Save has priority when both requests arrive together.
        if (bus.save_req) begin
          state_d = CTX_SAVE;
          base_d  = bus.base_addr;
          idx_d   = CTX_FIRST_IDX;
        end else if (bus.restore_req) begin
          state_d = CTX_REST_RD;
          base_d  = bus.base_addr;
          idx_d   = CTX_FIRST_IDX;
        end
      end
      CTX_SAVE: begin
        if (bus.mem_ready) begin
          if (idx_q == CTX_LAST_IDX) state_d = CTX_DONE;
          else                       idx_d   = idx_q + 5'd1;
        end
      end
      CTX_REST_RD: begin
        if (bus.mem_ready) begin
          data_d  = bus.mem_rdata;
          state_d = CTX_REST_WR;
        end
      end
      CTX_REST_WR: begin
        if (idx_q == CTX_LAST_IDX) begin
          state_d = CTX_DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = CTX_REST_RD;
        end
      end
      CTX_DONE: state_d = CTX_IDLE;
      default:  state_d = CTX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CTX_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  assign bus.busy      = (state_q != CTX_IDLE);
  assign bus.done      = (state_q == CTX_DONE);
  assign bus.reg_bank  = bus.busy;
  assign bus.reg_addr  = idx_q;
  assign bus.reg_wdata = data_q;
  assign bus.reg_write = (state_q == CTX_REST_WR);
  assign bus.mem_addr  = base_q + {27'd0, idx_q};
  // Gated so the memory bus stays quiet outside a save.
  assign bus.mem_wdata = (state_q == CTX_SAVE) ? bus.reg_rdata : 32'd0;
  assign bus.mem_we    = (state_q == CTX_SAVE);
  assign bus.mem_re    = (state_q == CTX_REST_RD);

endmodule

// File: tb/tb_ctx_switch_unit.sv
// Directed bench for ctx_switch_unit: table of save/restore scenarios plus reset-mid-restore.
module tb_ctx_switch_unit;

`ifdef CTX_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NX = 32 - FIRST;

  typedef struct {
    bit          save;
    bit          restore;
    logic [31:0] base;
    int          stall_mod;
    int          mid_req;
    int          tag;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    string       name;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  ctx_switch_unit_if bus();

  ctx_switch_unit dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  logic [31:0] regs [32];
  logic [31:0] mem  [1024];
  int checks = 0;
  int errors = 0;
  vec_t vecs [6];

  assign bus.reg_rdata = regs[bus.reg_addr];
  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

  function automatic logic [31:0] pat_save(input int tag, input int i);
    return 32'hA000_0000 + 32'(tag << 12) + 32'(i);
  endfunction

  function automatic logic [31:0] pat_rest(input int tag, input int i);
    return ~(32'(i) + 32'(tag << 12));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Register file and memory commit whatever the DUT presents this cycle.
  task automatic model_step();
    if (bus.mem_we && bus.mem_ready) mem[bus.mem_addr[9:0]] = bus.mem_wdata;
    if (bus.reg_write) regs[bus.reg_addr] = bus.reg_wdata;
  endtask

  task automatic run_op(input vec_t v);
    int cyc, done_cyc, stalls, nobusy, excl_bad, dir_bad, bank_bad, hold_bad, seq_bad, data_bad;
    logic        stall_prev;
    logic [31:0] snap_addr, snap_wdata, a;
    logic [31:0] alog [$];
    done_cyc = 0; stalls = 0; nobusy = 0; excl_bad = 0; dir_bad = 0;
    bank_bad = 0; hold_bad = 0; seq_bad = 0; data_bad = 0;
    stall_prev = 1'b0; snap_addr = '0; snap_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      a = v.base + 32'(i);
      if (v.save) begin
        regs[i] = pat_save(v.tag, i);
        mem[a[9:0]] = 32'hEEEE_0000 + 32'(i);
      end else begin
        regs[i] = 32'h5555_0000 + 32'(i);
        mem[a[9:0]] = pat_rest(v.tag, i);
      end
    end
    @(negedge clock);
    bus.save_req = v.save; bus.restore_req = v.restore;
    bus.base_addr = v.base; bus.mem_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.save_req = 1'b0; bus.restore_req = 1'b0; bus.base_addr = 32'h0;
    cyc = 1;
    while (done_cyc == 0 && cyc <= 400) begin
      bus.mem_ready   = !(v.stall_mod != 0 && (cyc % v.stall_mod) == 0);
      bus.restore_req = (cyc == v.mid_req);
      #1;
      if (!bus.busy) nobusy++;
      if (bus.mem_we && bus.mem_re) excl_bad++;
      if ((v.save && bus.mem_re) || (!v.save && bus.mem_we)) dir_bad++;
      if (bus.reg_write && !bus.reg_bank) bank_bad++;
      if (stall_prev && (bus.mem_addr !== snap_addr || bus.mem_wdata !== snap_wdata ||
                         !(bus.mem_we || bus.mem_re))) hold_bad++;
      stall_prev = 1'b0;
      if (bus.mem_we || bus.mem_re) begin
        if (!bus.mem_ready) begin
          stalls++; stall_prev = 1'b1;
          snap_addr = bus.mem_addr; snap_wdata = bus.mem_wdata;
        end else begin
          alog.push_back(bus.mem_addr);
        end
      end
      model_step();
      if (bus.done) done_cyc = cyc;
      else begin @(negedge clock); cyc++; end
    end
    bus.restore_req = 1'b0; bus.mem_ready = 1'b1;

    chk({v.name, " done_cycle"}, done_cyc, (v.save ? NX : 2 * NX) + stalls + 1);
    chk({v.name, " busy_gap"}, nobusy, 0);
    chk({v.name, " we_re_overlap"}, excl_bad, 0);
    chk({v.name, " wrong_direction"}, dir_bad, 0);
    chk({v.name, " bank_on_write"}, bank_bad, 0);
    chk({v.name, " stall_hold"}, hold_bad, 0);
    chk({v.name, " xfer_count"}, alog.size(), NX);
    if (alog.size() > 0) begin
      chk({v.name, " first_addr"}, alog[0], v.exp_first);
      chk({v.name, " last_addr"}, alog[alog.size() - 1], v.exp_last);
    end
    foreach (alog[j]) if (alog[j] !== v.base + 32'(FIRST + j)) seq_bad++;
    chk({v.name, " addr_sequence"}, seq_bad, 0);

    @(negedge clock); #1;
    chk({v.name, " idle_after_done"}, {30'd0, bus.done, bus.busy}, 32'd0);

    for (int i = 0; i < 32; i++) begin
      a = v.base + 32'(i);
      if (v.save) begin
        if (i < FIRST) begin
          if (mem[a[9:0]] !== 32'hEEEE_0000 + 32'(i)) data_bad++;
        end else if (mem[a[9:0]] !== pat_save(v.tag, i)) data_bad++;
      end else begin
        if (i < FIRST) begin
          if (regs[i] !== 32'h5555_0000 + 32'(i)) data_bad++;
        end else if (regs[i] !== pat_rest(v.tag, i)) data_bad++;
      end
    end
    chk({v.name, " data"}, data_bad, 0);
  endtask

  initial begin
    int wait_cyc, rst_bad;
    reset = 1'b1;
    bus.save_req = 1'b0; bus.restore_req = 1'b0;
    bus.base_addr = 32'h0; bus.mem_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_strobes", {29'd0, bus.reg_write, bus.mem_we, bus.mem_re}, 32'd0);
    chk("rst_bank", {31'd0, bus.reg_bank}, 32'd0);
    chk("rst_reg_addr", {27'd0, bus.reg_addr}, 32'd0);
    chk("rst_reg_wdata", bus.reg_wdata, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 0, 0, 0, 32'h0000_0100 + FIRST, 32'h0000_011F, "save_basic"};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 0, 0, 0, 32'h0000_0200 + FIRST, 32'h0000_021F, "restore_basic"};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0300, 3, 0, 2, 32'h0000_0300 + FIRST, 32'h0000_031F, "save_stall3"};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 0, 0, 3, 32'hFFFF_FFF0 + FIRST, 32'h0000_000F, "save_wrap"};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0140, 0, 5, 4, 32'h0000_0140 + FIRST, 32'h0000_015F, "both_req"};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0300, 2, 0, 5, 32'h0000_0300 + FIRST, 32'h0000_031F, "restore_stall2"};
    foreach (vecs[r]) run_op(vecs[r]);

    // Reset while REST_RD is fetching slot 10: nothing from 10 onward may land.
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'h5555_0000 + 32'(i);
      mem[10'h200 + 10'(i)] = pat_rest(0, i);
    end
    @(negedge clock);
    bus.restore_req = 1'b1; bus.base_addr = 32'h0000_0200;
    @(posedge clock);
    @(negedge clock); #1;
    bus.restore_req = 1'b0; bus.base_addr = 32'h0;
    wait_cyc = 0;
    while (!(bus.mem_re && bus.mem_addr == 32'h0000_020A) && wait_cyc < 200) begin
      model_step();
      @(negedge clock); #1;
      wait_cyc++;
    end
    chk("rst_mid_reached_idx10", {31'd0, bus.mem_re}, 32'd1);
    reset = 1'b1;
    @(negedge clock); #1;
    chk("rst_mid_idle", {27'd0, bus.busy, bus.done, bus.reg_write, bus.mem_we, bus.mem_re}, 32'd0);
    reset = 1'b0;
    @(negedge clock); #1;
    chk("rst_mid_stays_idle", {31'd0, bus.busy}, 32'd0);
    rst_bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (i >= FIRST && i < 10) begin
        if (regs[i] !== pat_rest(0, i)) rst_bad++;
      end else if (regs[i] !== 32'h5555_0000 + 32'(i)) rst_bad++;
    end
    chk("rst_mid_regs", rst_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
